// File: rtl/shoelace_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : shoelace_pkg
//  Description : Shared definitions for the shoelace token sequencer:
//                FSM state encoding and default statistic/timeout sizing.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package shoelace_pkg;

    // Sequencer states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int DEF_LAT_W   = 8;
    localparam int DEF_TIMEOUT = 200;
    localparam int TOK_W       = 16;

endpackage : shoelace_pkg
`default_nettype wire

// File: rtl/shoelace_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : shoelace_sync
//  Description : Multi-flop bit synchronizer for the asynchronous chain
//                output. Resets to a caller-chosen value so that a settled
//                chain reads as "quiet" immediately after reset.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset
//                async_i - asynchronous input bit
//                sync_o  - synchronized output (SYNC_STAGES cycles late)
//  Revision    : 1.0 - initial release
// ============================================================================
module shoelace_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] ff_q;

    generate
        if (SYNC_STAGES == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) ff_q <= RST_VAL;
                else     ff_q <= async_i;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) ff_q <= {SYNC_STAGES{RST_VAL}};
                else     ff_q <= {ff_q[SYNC_STAGES-2:0], async_i};
            end
        end
    endgenerate

    assign sync_o = ff_q[SYNC_STAGES-1];

endmodule : shoelace_sync
`default_nettype wire

// File: rtl/shoelace_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : shoelace_sequencer
//  Description : Launches one transition at a time into an external inverter
//                chain, waits for the matching edge at the chain output and
//                measures round-trip latency in clk cycles. Keeps last/min/max
//                latency and aborts on timeout or a non-quiescent chain.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, num_tokens   - run request (sampled in IDLE only)
//                chain_in/chain_out  - drive to / async return from chain
//                busy, done          - run in progress / end-of-run pulse
//                tok_count           - tokens completed this run
//                lat_last/min/max    - latency statistics
//                timeout_err         - sticky: output edge never arrived
//                quiet_err           - sticky: chain unsettled at launch
//  Revision    : 1.0 - initial release
// ============================================================================
module shoelace_sequencer
    import shoelace_pkg::*;
#(
    parameter int STAGES      = 5,
    parameter int LAT_W       = DEF_LAT_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int GAP         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TOK_W-1:0] num_tokens,
    output logic             chain_in,
    input  logic             chain_out,
    output logic             busy,
    output logic             done,
    output logic [TOK_W-1:0] tok_count,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic             timeout_err,
    output logic             quiet_err
);

    // Odd stage count inverts, so the settled output is chain_in ^ INV.
    localparam logic             INV       = 1'((STAGES % 2) != 0);
    localparam logic [LAT_W-1:0] LAT_ONES  = '1;
    localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT);
    localparam int               GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_e             state_q,    state_d;
    logic               chain_in_q, chain_in_d;
    logic [TOK_W-1:0]   num_q,      num_d;
    logic [TOK_W-1:0]   tok_q,      tok_d;
    logic [LAT_W-1:0]   cnt_q,      cnt_d;
    logic [LAT_W-1:0]   last_q,     last_d;
    logic [LAT_W-1:0]   min_q,      min_d;
    logic [LAT_W-1:0]   max_q,      max_d;
    logic               tout_q,     tout_d;
    logic               quiet_q,    quiet_d;
    logic [GAP_W-1:0]   gap_q,      gap_d;

    logic               sout;
    logic               exp_lvl;
    logic [TOK_W-1:0]   tok_inc;

    shoelace_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (INV)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (chain_out),
        .sync_o  (sout)
    );

    // chain_in_q is already the post-launch value while in WAIT, so the same
    // expression serves both the quiescence check and the edge detection.
    assign exp_lvl = chain_in_q ^ INV;
    assign tok_inc = tok_q + TOK_W'(1);

    always_comb begin
        state_d    = state_q;
        chain_in_d = chain_in_q;
        num_d      = num_q;
        tok_d      = tok_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        min_d      = min_q;
        max_d      = max_q;
        tout_d     = tout_q;
        quiet_d    = quiet_q;
        gap_d      = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_tokens;
                    tok_d   = '0;
                    last_d  = '0;
                    min_d   = LAT_ONES;
                    max_d   = '0;
                    tout_d  = 1'b0;
                    quiet_d = 1'b0;
                    state_d = (num_tokens == '0) ? ST_DONE : ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                if (sout != exp_lvl) begin
                    // Chain still carrying a previous edge; abort untouched.
                    quiet_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    chain_in_d = ~chain_in_q;
                    cnt_d      = LAT_W'(1);
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (sout == exp_lvl) begin
                    last_d = cnt_q;
                    tok_d  = tok_inc;
                    if (tok_q == '0) begin
                        min_d = cnt_q;
                        max_d = cnt_q;
                    end else begin
                        if (cnt_q < min_q) min_d = cnt_q;
                        if (cnt_q > max_q) max_d = cnt_q;
                    end
                    gap_d = '0;
                    if (GAP == 0) begin
                        state_d = (tok_inc < num_q) ? ST_LAUNCH : ST_DONE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (cnt_q == TIMEOUT_V) begin
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q != LAT_ONES) begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (tok_q < num_q) ? ST_LAUNCH : ST_DONE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            chain_in_q <= 1'b0;
            num_q      <= '0;
            tok_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            min_q      <= LAT_ONES;
            max_q      <= '0;
            tout_q     <= 1'b0;
            quiet_q    <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            chain_in_q <= chain_in_d;
            num_q      <= num_d;
            tok_q      <= tok_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            min_q      <= min_d;
            max_q      <= max_d;
            tout_q     <= tout_d;
            quiet_q    <= quiet_d;
            gap_q      <= gap_d;
        end
    end

    assign chain_in    = chain_in_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign tok_count   = tok_q;
    assign lat_last    = last_q;
    assign lat_min     = min_q;
    assign lat_max     = max_q;
    assign timeout_err = tout_q;
    assign quiet_err   = quiet_q;

endmodule : shoelace_sequencer
`default_nettype wire
